// File: rtl/cpu_params.sv
// Shared backend parameters and the CDB packet type.
// CDB_ARB_RVFI_EN adds rs1/rs2 debug values to every packet.
package cpu_params;

  localparam int unsigned CDB_WIDTH = 2;
  localparam int unsigned ROB_IDX   = 5;
  localparam int unsigned PRF_IDX   = 6;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic [PRF_IDX-1:0] rd_phy;
    logic [31:0]        rd_value;
`ifdef CDB_ARB_RVFI_EN
    logic [31:0]        rs1_dbg;
    logic [31:0]        rs2_dbg;
`endif
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_rr_select.sv
// Combinational round-robin picker: scans from i_rr_ptr and hands the k-th
// occupied slot to CDB port k.
module cdb_rr_select #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CDB_WIDTH = 2,
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]              i_occ,
  input  logic [PTR_W-1:0]                i_rr_ptr,
  output logic [CDB_WIDTH-1:0][PTR_W-1:0] o_port_idx,
  output logic [CDB_WIDTH-1:0]            o_port_vld,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [PTR_W-1:0]                o_next_ptr
);

  int unsigned      w_cnt;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_port_idx = '0;
    o_port_vld = '0;
    o_grant    = '0;
    o_next_ptr = i_rr_ptr;
    w_cnt      = 0;
    w_idx      = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_idx = PTR_W'((32'(i_rr_ptr) + j) % NUM_REQ);
      if (i_occ[w_idx] && (w_cnt < CDB_WIDTH)) begin
        o_grant[w_idx] = 1'b1;
        for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
          if (w_cnt == k) begin
            o_port_vld[k] = 1'b1;
            o_port_idx[k] = w_idx;
          end
        end
        o_next_ptr = PTR_W'((32'(w_idx) + 1) % NUM_REQ);
        w_cnt      = w_cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-unit result holding slots arbitrated round-robin onto registered CDB ports.
// CDB_ARB_RVFI_EN carries rs1/rs2 debug values alongside each result.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CDB_WIDTH = cpu_params::CDB_WIDTH,
  parameter int unsigned ROB_IDX   = cpu_params::ROB_IDX,
  parameter int unsigned PRF_IDX   = cpu_params::PRF_IDX
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][ROB_IDX-1:0]   req_rob_id,
  input  logic [NUM_REQ-1:0][PRF_IDX-1:0]   req_rd_phy,
  input  logic [NUM_REQ-1:0][31:0]          req_rd_value,
`ifdef CDB_ARB_RVFI_EN
  input  logic [NUM_REQ-1:0][31:0]          req_rs1_dbg,
  input  logic [NUM_REQ-1:0][31:0]          req_rs2_dbg,
  output logic [CDB_WIDTH-1:0][31:0]        cdb_rs1_dbg,
  output logic [CDB_WIDTH-1:0][31:0]        cdb_rs2_dbg,
`endif
  output logic [CDB_WIDTH-1:0]              cdb_valid,
  output logic [CDB_WIDTH-1:0][ROB_IDX-1:0] cdb_rob_id,
  output logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cdb_rd_phy,
  output logic [CDB_WIDTH-1:0][31:0]        cdb_rd_value
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]     r_occ;
  cpu_params::cdb_pkt_t   r_slot [NUM_REQ];
  cpu_params::cdb_pkt_t   r_cdb  [CDB_WIDTH];
  logic [CDB_WIDTH-1:0]   r_cdb_valid;
  logic [PTR_W-1:0]       r_rr_ptr;

  logic [CDB_WIDTH-1:0][PTR_W-1:0] w_port_idx;
  logic [CDB_WIDTH-1:0]            w_port_vld;
  logic [NUM_REQ-1:0]              w_grant;
  logic [PTR_W-1:0]                w_next_ptr;
  logic [NUM_REQ-1:0]              w_load;
  cpu_params::cdb_pkt_t            w_in_pkt [NUM_REQ];

  cdb_rr_select #(
    .NUM_REQ   (NUM_REQ),
    .CDB_WIDTH (CDB_WIDTH)
  ) u_select (
    .i_occ      (r_occ),
    .i_rr_ptr   (r_rr_ptr),
    .o_port_idx (w_port_idx),
    .o_port_vld (w_port_vld),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr)
  );

  // A granted slot frees up this cycle, so it can be refilled back-to-back.
  assign req_ready = ~r_occ | w_grant;
  assign w_load    = req_valid & req_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_in_pkt[i]          = '0;
      w_in_pkt[i].rob_id   = req_rob_id[i];
      w_in_pkt[i].rd_phy   = req_rd_phy[i];
      w_in_pkt[i].rd_value = req_rd_value[i];
`ifdef CDB_ARB_RVFI_EN
      w_in_pkt[i].rs1_dbg  = req_rs1_dbg[i];
      w_in_pkt[i].rs2_dbg  = req_rs2_dbg[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ       <= '0;
      r_cdb_valid <= '0;
      r_rr_ptr    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_slot[i] <= '0;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) r_cdb[k] <= '0;
    end else if (flush) begin
      r_occ       <= '0;
      r_cdb_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_load[i]) begin
          r_occ[i]  <= 1'b1;
          r_slot[i] <= w_in_pkt[i];
        end else if (w_grant[i]) begin
          r_occ[i]  <= 1'b0;
        end
      end
      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        r_cdb_valid[k] <= w_port_vld[k];
        if (w_port_vld[k]) r_cdb[k] <= r_slot[w_port_idx[k]];
      end
      if (|w_grant) r_rr_ptr <= w_next_ptr;
    end
  end

  always_comb begin
    cdb_valid = r_cdb_valid;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      cdb_rob_id[k]   = r_cdb[k].rob_id;
      cdb_rd_phy[k]   = r_cdb[k].rd_phy;
      cdb_rd_value[k] = r_cdb[k].rd_value;
`ifdef CDB_ARB_RVFI_EN
      cdb_rs1_dbg[k]  = r_cdb[k].rs1_dbg;
      cdb_rs2_dbg[k]  = r_cdb[k].rs2_dbg;
`endif
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a behavioural model queues expected
// broadcasts at each edge; a monitor checks them on the following falling edge.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int RB = 5;
  localparam int PR = 6;
`ifdef CDB_ARB_RVFI_EN
  localparam int PW = RB + PR + 32 + 64;
`else
  localparam int PW = RB + PR + 32;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0][RB-1:0] req_rob_id = '0;
  logic [N-1:0][PR-1:0] req_rd_phy = '0;
  logic [N-1:0][31:0]   req_rd_value = '0;
  logic [W-1:0]         cdb_valid;
  logic [W-1:0][RB-1:0] cdb_rob_id;
  logic [W-1:0][PR-1:0] cdb_rd_phy;
  logic [W-1:0][31:0]   cdb_rd_value;
`ifdef CDB_ARB_RVFI_EN
  logic [N-1:0][31:0]   req_rs1_dbg = '0;
  logic [N-1:0][31:0]   req_rs2_dbg = '0;
  logic [W-1:0][31:0]   cdb_rs1_dbg;
  logic [W-1:0][31:0]   cdb_rs2_dbg;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ   (N),
    .CDB_WIDTH (W),
    .ROB_IDX   (RB),
    .PRF_IDX   (PR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rob_id   (req_rob_id),
    .req_rd_phy   (req_rd_phy),
    .req_rd_value (req_rd_value),
`ifdef CDB_ARB_RVFI_EN
    .req_rs1_dbg  (req_rs1_dbg),
    .req_rs2_dbg  (req_rs2_dbg),
    .cdb_rs1_dbg  (cdb_rs1_dbg),
    .cdb_rs2_dbg  (cdb_rs2_dbg),
`endif
    .cdb_valid    (cdb_valid),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_rd_phy   (cdb_rd_phy),
    .cdb_rd_value (cdb_rd_value)
  );

  typedef struct {
    int unsigned  cyc;
    int           port;
    logic [PW-1:0] pay;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_mis = 0;
  int unsigned cyc = 0;
  int unsigned rd = 0;

  bit   [N-1:0]  m_occ = '0;
  int            m_ptr = 0;
  logic [PW-1:0] m_slot [N];
  int            m_g [W];
  int            m_ng;

  function automatic logic [PW-1:0] pay_in(input int i);
`ifdef CDB_ARB_RVFI_EN
    return {req_rob_id[i], req_rd_phy[i], req_rd_value[i], req_rs1_dbg[i], req_rs2_dbg[i]};
`else
    return {req_rob_id[i], req_rd_phy[i], req_rd_value[i]};
`endif
  endfunction

  function automatic logic [PW-1:0] pay_out(input int k);
`ifdef CDB_ARB_RVFI_EN
    return {cdb_rob_id[k], cdb_rd_phy[k], cdb_rd_value[k], cdb_rs1_dbg[k], cdb_rs2_dbg[k]};
`else
    return {cdb_rob_id[k], cdb_rd_phy[k], cdb_rd_value[k]};
`endif
  endfunction

  // Occupied units in rotated order starting at ptr; the first W win.
  function automatic void pick(input bit [N-1:0] occ, input int ptr,
                               output int g[W], output int ng);
    ng = 0;
    for (int k = 0; k < W; k++) g[k] = 0;
    for (int j = 0; j < N; j++) begin
      int i;
      i = (ptr + j) % N;
      if (occ[i] && ng < W) begin
        g[ng] = i;
        ng++;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g[W];
    int ng;
    logic [N-1:0] r;
    pick(m_occ, m_ptr, g, ng);
    r = ~m_occ;
    for (int k = 0; k < ng; k++) r[g[k]] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_occ = '0;
      m_ptr = 0;
    end else begin
      cyc = cyc + 1;
      if (flush) begin
        m_occ = '0;
      end else begin
        pick(m_occ, m_ptr, m_g, m_ng);
        for (int k = 0; k < m_ng; k++) begin
          sb.push_back('{cyc: cyc, port: k, pay: m_slot[m_g[k]]});
          m_occ[m_g[k]] = 1'b0;
        end
        if (m_ng > 0) m_ptr = (m_g[m_ng-1] + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && !m_occ[i]) begin
            m_occ[i]  = 1'b1;
            m_slot[i] = pay_in(i);
          end
        end
      end
    end
  end

  logic [W-1:0] mon_ev;
  logic [N-1:0] mon_rdy;

  always begin
    @(negedge clk or posedge rst);
    if (rst) begin
      #1;
      n_vec++;
      if (cdb_valid !== '0) begin
        n_mis++;
        $display("FAIL reset_valid: cdb_valid=%b required %b", cdb_valid, {W{1'b0}});
      end
      n_vec++;
      if (req_ready !== '1) begin
        n_mis++;
        $display("FAIL reset_ready: req_ready=%b required %b", req_ready, {N{1'b1}});
      end
    end else begin
      mon_ev = '0;
      while (rd < sb.size() && sb[rd].cyc < cyc) begin
        n_vec++;
        n_mis++;
        $display("FAIL stale_result: result for cycle %0d not broadcast (now %0d)", sb[rd].cyc, cyc);
        rd++;
      end
      while (rd < sb.size() && sb[rd].cyc == cyc) begin
        mon_ev[sb[rd].port] = 1'b1;
        n_vec++;
        if (pay_out(sb[rd].port) !== sb[rd].pay) begin
          n_mis++;
          $display("FAIL cdb_payload port%0d cycle %0d: got %h required %h",
                   sb[rd].port, cyc, pay_out(sb[rd].port), sb[rd].pay);
        end
        rd++;
      end
      n_vec++;
      if (cdb_valid !== mon_ev) begin
        n_mis++;
        $display("FAIL cdb_valid cycle %0d: got %b required %b", cyc, cdb_valid, mon_ev);
      end
      mon_rdy = exp_ready();
      n_vec++;
      if (req_ready !== mon_rdy) begin
        n_mis++;
        $display("FAIL req_ready cycle %0d: got %b required %b", cyc, req_ready, mon_rdy);
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic fl);
    @(negedge clk);
    req_valid = v;
    flush     = fl;
    for (int i = 0; i < N; i++) begin
      req_rob_id[i]   = RB'($urandom);
      req_rd_phy[i]   = PR'($urandom);
      req_rd_value[i] = $urandom;
`ifdef CDB_ARB_RVFI_EN
      req_rs1_dbg[i]  = $urandom;
      req_rs2_dbg[i]  = $urandom;
`endif
    end
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++)
      step(N'($urandom), ($urandom_range(99) < 3));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // every unit requests every cycle starting from rr_ptr = 0
    repeat (8) step('1, 1'b0);
    repeat (4) step('0, 1'b0);

    step(4'b0100, 1'b0);
    req_rob_id[2]   = 5'd5;
    req_rd_phy[2]   = 6'd9;
    req_rd_value[2] = 32'hDEADBEEF;
    repeat (4) step('0, 1'b0);

    step(4'b0011, 1'b0);
    step(4'b1101, 1'b0);
    step(4'b1100, 1'b0);
    step(4'b0001, 1'b0);
    repeat (4) step('0, 1'b0);

    // slots 1 and 3 loaded, then flushed while unit 0 handshakes
    step(4'b1010, 1'b0);
    step(4'b0001, 1'b1);
    repeat (4) step('0, 1'b0);

    random_phase(1500);

    repeat (3) step('1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;

    random_phase(1500);
    repeat (4) step('0, 1'b0);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the CDB broadcast ports among the backend functional units. Each unit hands its completed result (ROB id, physical destination, value) to a per-unit holding slot. A round-robin scheduler then grants up to CDB_WIDTH slots per cycle onto registered CDB ports, which the ROB, reservation stations and PRF snoop. Sits between the functional-unit writeback stages and the CDB; a backend flush squashes all in-flight results.

## Interface
- NUM_REQ, default 4: number of requesting functional units; must be ≥ CDB_WIDTH.
- CDB_WIDTH, default 2: number of CDB broadcast ports.
- ROB_IDX, default 5: ROB id width.
- PRF_IDX, default 6: physical register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  backend flush (ROB mispredict dequeue).
- req_valid  in  [NUM_REQ]  unit i presents a result.
- req_ready  out  [NUM_REQ]  slot i can accept this cycle.
- req_rob_id  in  [NUM_REQ][ROB_IDX]  result ROB id.
- req_rd_phy  in  [NUM_REQ][PRF_IDX]  destination physical register.
- req_rd_value  in  [NUM_REQ][32]  result value.
- req_rs1_dbg, req_rs2_dbg  in  [NUM_REQ][32]  source values; present only with CDB_ARB_RVFI_EN.
- cdb_valid  out  [CDB_WIDTH]  broadcast k valid.
- cdb_rob_id, cdb_rd_phy, cdb_rd_value  out  per port  broadcast payload.
- cdb_rs1_dbg, cdb_rs2_dbg  out  [CDB_WIDTH][32]  only with CDB_ARB_RVFI_EN.

## Operation
- Per requester, one holding slot with an occupied bit and a payload.
- req_ready[i] = ~occ[i] | grant[i]. This is combinational and independent of req_valid.
- Handshake req_valid[i] & req_ready[i] loads slot i and sets occ[i].
- A slot that is granted and refilled in the same cycle stays occupied with the new payload.
- Selection scans i = rr_ptr, rr_ptr+1, … (mod NUM_REQ) over occupied slots. The k-th occupied slot found is granted to port k, for k < CDB_WIDTH.
- Ungranted ports load cdb_valid = 0. Their payload registers hold their old value.
- Granted slot: occ cleared unless refilled that cycle. Port k output registers load the slot payload, and cdb_valid[k] is set.
- rr_ptr (width $clog2(NUM_REQ)) advances to (index of last grant + 1) mod NUM_REQ. It is unchanged when nothing is granted.
- Flush (synchronous, has priority over everything else):
  - clears all occ bits and all cdb_valid;
  - discards handshakes in the flush cycle;
  - leaves rr_ptr unchanged.
- Reset (asynchronous): occ = 0, cdb_valid = 0, rr_ptr = 0, payload registers = 0.

## Timing
- Latency: a handshake at edge E0 makes the result eligible in the next cycle. The grant loads the output at E1, so cdb_valid is seen in the cycle after E1. Minimum latency is 2 cycles.
- Throughput: each slot sustains one result per cycle when granted every cycle (refill in the grant cycle).
- All CDB outputs are registered. req_ready is combinational from state.
- Each cdb_valid pulse lasts exactly one cycle per granted result. There is no backpressure from the CDB.
- Reset asserted mid-operation clears state immediately, with no clock needed. Outputs read 0 until the first edge after reset deasserts.
- Flush asserted at edge E: cdb_valid = 0 and all req_ready = 1 in the cycle after E.

## Configuration
- CDB_ARB_RVFI_EN defined:
  - rs1/rs2 debug ports and slot fields exist;
  - they are carried with the payload under identical timing;
  - the ROB uses them for RVFI rs1_rdata/rs2_rdata.
- CDB_ARB_RVFI_EN undefined: those ports and storage are absent. Everything else is identical.

## Structure
- cpu_params (shared package) holds:
  - CDB_WIDTH, ROB_IDX, PRF_IDX;
  - typedef cdb_pkt_t {rob_id, rd_phy, rd_value, and under the macro rs1_dbg and rs2_dbg}.
- Slots and output registers are of type cdb_pkt_t.
- One sub-module, cdb_rr_select: purely combinational. Inputs are occ and rr_ptr; outputs are per-port grant index plus valid, the grant vector, and next rr_ptr.

## Test plan
- Single result: unit 2 presents rob_id 5, rd_phy 9, value 0xDEADBEEF at E0 → cdb_valid[0] = 1 with that payload in the cycle after E1, for one cycle only; req_ready[2] stays 1 throughout.
- All four units valid every cycle with rr_ptr = 0 → grants alternate {0,1}, {2,3}, {0,1}. Each unit sustains a 50% grant rate, and every accepted result appears exactly once.
- Saturation: units 0 and 1 each hold one result while units 2 and 3 are requesting. A new result refilled into slot 0 in its grant cycle is broadcast after units 2 and 3 are served, so there is no starvation.
- Flush while slots 1 and 3 are occupied and unit 0 is handshaking → next cycle cdb_valid = 00 and all occ are 0; none of those three results ever appears on the CDB.
- Async reset pulse between edges with cdb_valid = 11 → cdb_valid drops to 00 before the next edge, and rr_ptr reads 0.
- Wrap-around: rr_ptr = 3 with slots 3 and 0 occupied → port 0 carries slot 3, port 1 carries slot 0, and the new rr_ptr = 1.
